// File: rtl/pulse_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_mon_pkg
// Description : Shared types and constants for the pulse monitor: FSM state
//               encoding, statistics counter widths and saturating
//               increment helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_mon_pkg;

    // 2'd3 is left unused; the monitor FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int PULSE_CNT_W = 16;
    localparam int ERR_CNT_W   = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PULSE_CNT_W-1:0] sat_inc_pulse(
        input logic [PULSE_CNT_W-1:0] v
    );
        return (&v) ? v : v + PULSE_CNT_W'(1);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc_err(
        input logic [ERR_CNT_W-1:0] v
    );
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_monitor_if
// Description : Strobe input and status outputs of the pulse monitor.
//               master = monitor side, slave = strobe source / observer.
//               Optional statistics ports exist only when
//               PULSE_MON_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_monitor_if #(
    parameter int CNT_W = 8
) ();

    logic             signal;
    logic             locked;
    logic [CNT_W-1:0] interval;
    logic             interval_valid;
    logic             early;
    logic             missing;

`ifdef PULSE_MON_STATS_EN
    logic [pulse_mon_pkg::PULSE_CNT_W-1:0] pulse_count;
    logic [pulse_mon_pkg::ERR_CNT_W-1:0]   err_count;

    modport master (
        input  signal,
        output locked, interval, interval_valid, early, missing,
        output pulse_count, err_count
    );

    modport slave (
        output signal,
        input  locked, interval, interval_valid, early, missing,
        input  pulse_count, err_count
    );
`else
    modport master (
        input  signal,
        output locked, interval, interval_valid, early, missing
    );

    modport slave (
        output signal,
        input  locked, interval, interval_valid, early, missing
    );
`endif

endinterface
`default_nettype wire

// File: rtl/pulse_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : pulse_edge_detect
// Description : Rising-edge detector for a synchronous strobe. A level held
//               high for many cycles yields a single one-cycle edge pulse.
//               Reusable by any strobe consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic i_signal,
    output logic o_edge
);

    logic r_prev;

    // Remember the strobe level from the previous cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_signal;
        end
    end

    assign o_edge = i_signal & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pulse_monitor
// Description : Receive-side checker for a periodic one-cycle strobe.
//               Measures edge-to-edge intervals, locks after LOCK_COUNT
//               consecutive on-period intervals, then flags early and
//               missing pulses.
//               Optional feature macro: PULSE_MON_STATS_EN adds saturating
//               pulse_count / err_count statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_monitor
    import pulse_mon_pkg::*;
#(
    parameter int PERIOD     = 3,
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    pulse_monitor_if.master bus
);

    // match_cnt must be able to hold LOCK_COUNT itself.
    localparam int MATCH_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   c_GAP_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_PERIOD      = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]   c_EXPECT_GAP  = CNT_W'(PERIOD - 1);
    localparam logic [MATCH_W-1:0] c_LOCK_TARGET = MATCH_W'(LOCK_COUNT);

    logic               w_edge;
    logic [CNT_W-1:0]   w_measured;
    logic               w_on_period;
    logic [MATCH_W-1:0] w_match_next;
    logic               w_early_evt;
    logic               w_missing_evt;

    state_t             r_state;
    logic [CNT_W-1:0]   r_gap;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [CNT_W-1:0]   r_interval;
    logic               r_locked;
    logic               r_valid;
    logic               r_early;
    logic               r_missing;

    pulse_edge_detect u_edge (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_signal (bus.signal),
        .o_edge   (w_edge)
    );

    // Interval of the edge arriving this cycle, including the edge cycle.
    assign w_measured   = (r_gap == c_GAP_MAX) ? c_GAP_MAX : r_gap + CNT_W'(1);
    assign w_on_period  = (w_measured == c_PERIOD);
    assign w_match_next = r_match_cnt + MATCH_W'(1);

    // Early and missing are exclusive: one needs an edge, the other none.
    assign w_early_evt   = (r_state == LOCKED) & w_edge & (w_measured < c_PERIOD);
    assign w_missing_evt = (r_state == LOCKED) & ~w_edge & (r_gap == c_EXPECT_GAP);

    // Cycles since the last edge, cleared on an edge, saturating.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gap <= '0;
        end else if (w_edge) begin
            r_gap <= '0;
        end else if (r_gap != c_GAP_MAX) begin
            r_gap <= r_gap + CNT_W'(1);
        end
    end

    // Lock FSM with registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_match_cnt <= '0;
            r_interval  <= '0;
            r_locked    <= 1'b0;
            r_valid     <= 1'b0;
            r_early     <= 1'b0;
            r_missing   <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_early   <= 1'b0;
            r_missing <= 1'b0;
            case (r_state)
                IDLE: begin
                    // First edge only starts the measurement; no interval yet.
                    if (w_edge) begin
                        r_state     <= ACQUIRE;
                        r_match_cnt <= '0;
                    end
                end

                ACQUIRE: begin
                    if (w_edge) begin
                        r_interval <= w_measured;
                        r_valid    <= 1'b1;
                        if (w_on_period) begin
                            if (w_match_next == c_LOCK_TARGET) begin
                                r_state     <= LOCKED;
                                r_locked    <= 1'b1;
                                r_match_cnt <= '0;
                            end else begin
                                r_match_cnt <= w_match_next;
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end
                end

                LOCKED: begin
                    if (w_edge) begin
                        r_interval <= w_measured;
                        r_valid    <= 1'b1;
                    end
                    if (w_early_evt) begin
                        r_early     <= 1'b1;
                        r_state     <= ACQUIRE;
                        r_locked    <= 1'b0;
                        r_match_cnt <= '0;
                    end else if (w_missing_evt) begin
                        r_missing   <= 1'b1;
                        r_state     <= ACQUIRE;
                        r_locked    <= 1'b0;
                        r_match_cnt <= '0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_locked    <= 1'b0;
                    r_match_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.locked         = r_locked;
    assign bus.interval       = r_interval;
    assign bus.interval_valid = r_valid;
    assign bus.early          = r_early;
    assign bus.missing        = r_missing;

`ifdef PULSE_MON_STATS_EN
    logic [PULSE_CNT_W-1:0] r_pulse_count;
    logic [ERR_CNT_W-1:0]   r_err_count;

    // Saturating edge and error event counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_count <= '0;
            r_err_count   <= '0;
        end else begin
            if (w_edge) begin
                r_pulse_count <= sat_inc_pulse(r_pulse_count);
            end
            if (w_early_evt || w_missing_evt) begin
                r_err_count <= sat_inc_err(r_err_count);
            end
        end
    end

    assign bus.pulse_count = r_pulse_count;
    assign bus.err_count   = r_err_count;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
